// File: rtl/e_alu_iq.sv
// Four-entry collapsing ALU issue queue with wakeup bypass and a single output register.
// Slot 0 always holds the oldest instruction; issue picks the oldest entry whose operands are both ready.
module e_alu_iq (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush_i,
    input  logic        dsp_valid_i,
    output logic        dsp_ready_o,
    input  logic [2:0]  dsp_grand_op_i,
    input  logic [2:0]  dsp_op_i,
    input  logic [31:0] dsp_pc_i,
    input  logic        dsp_src0_rdy_i,
    input  logic [5:0]  dsp_src0_tag_i,
    input  logic [31:0] dsp_src0_data_i,
    input  logic        dsp_src1_rdy_i,
    input  logic [5:0]  dsp_src1_tag_i,
    input  logic [31:0] dsp_src1_data_i,
    input  logic [5:0]  dsp_dst_tag_i,
    input  logic        wk_valid_i,
    input  logic [5:0]  wk_tag_i,
    input  logic [31:0] wk_data_i,
    output logic        iss_valid_o,
    input  logic        iss_ready_i,
    output logic [31:0] iss_r0_o,
    output logic [31:0] iss_r1_o,
    output logic [31:0] iss_pc_o,
    output logic [2:0]  iss_grand_op_o,
    output logic [2:0]  iss_op_o,
    output logic [5:0]  iss_dst_tag_o
);

    typedef struct packed {
        logic        valid;
        logic [2:0]  grand_op;
        logic [2:0]  op;
        logic [31:0] pc;
        logic [5:0]  dst_tag;
        logic        src0_rdy;
        logic [5:0]  src0_tag;
        logic [31:0] src0_data;
        logic        src1_rdy;
        logic [5:0]  src1_tag;
        logic [31:0] src1_data;
    } entry_t;

    // Only operands still waiting capture the broadcast; ready ones keep their value.
    function automatic entry_t wake(input entry_t e, input logic wv,
                                    input logic [5:0] wt, input logic [31:0] wd);
        entry_t r;
        r = e;
        if (wv && !r.src0_rdy && (r.src0_tag == wt)) begin
            r.src0_rdy  = 1'b1;
            r.src0_data = wd;
        end
        if (wv && !r.src1_rdy && (r.src1_tag == wt)) begin
            r.src1_rdy  = 1'b1;
            r.src1_data = wd;
        end
        return r;
    endfunction

    entry_t      ent_q [4];
    entry_t      ent_d [4];
    entry_t      woken [5];
    entry_t      dsp_ent;
    logic [3:0]  elig;
    logic [2:0]  occ;
    logic [1:0]  sel_idx;
    logic [1:0]  free_idx;
    logic        has_elig;
    logic        load;
    logic        dsp_fire;

    logic        iss_valid_q, iss_valid_d;
    logic [31:0] iss_r0_q, iss_r0_d;
    logic [31:0] iss_r1_q, iss_r1_d;
    logic [31:0] iss_pc_q, iss_pc_d;
    logic [2:0]  iss_grand_op_q, iss_grand_op_d;
    logic [2:0]  iss_op_q, iss_op_d;
    logic [5:0]  iss_dst_tag_q, iss_dst_tag_d;

    always_comb begin
        occ  = '0;
        elig = '0;
        for (int i = 0; i < 4; i++) begin
            occ     = occ + 3'(ent_q[i].valid);
            elig[i] = ent_q[i].valid && ent_q[i].src0_rdy && ent_q[i].src1_rdy;
        end
        has_elig = |elig;
        sel_idx  = '0;
        for (int i = 3; i >= 0; i--) begin
            if (elig[i]) sel_idx = 2'(i);
        end
    end

    assign dsp_ready_o = (occ < 3'd4);
    assign dsp_fire    = dsp_valid_i && dsp_ready_o;
    assign load        = has_elig && (!iss_valid_q || iss_ready_i);

    // Collapse past the issuing slot first, then append the new instruction behind the survivors.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            woken[i] = wake(ent_q[i], wk_valid_i, wk_tag_i, wk_data_i);
        end
        woken[4] = '0;

        dsp_ent           = '0;
        dsp_ent.valid     = 1'b1;
        dsp_ent.grand_op  = dsp_grand_op_i;
        dsp_ent.op        = dsp_op_i;
        dsp_ent.pc        = dsp_pc_i;
        dsp_ent.dst_tag   = dsp_dst_tag_i;
        dsp_ent.src0_rdy  = dsp_src0_rdy_i;
        dsp_ent.src0_tag  = dsp_src0_tag_i;
        dsp_ent.src0_data = dsp_src0_data_i;
        dsp_ent.src1_rdy  = dsp_src1_rdy_i;
        dsp_ent.src1_tag  = dsp_src1_tag_i;
        dsp_ent.src1_data = dsp_src1_data_i;
        dsp_ent           = wake(dsp_ent, wk_valid_i, wk_tag_i, wk_data_i);

        for (int i = 0; i < 4; i++) begin
            ent_d[i] = (load && (2'(i) >= sel_idx)) ? woken[i+1] : woken[i];
        end
        free_idx = occ[1:0] - {1'b0, load};
        if (dsp_fire) ent_d[free_idx] = dsp_ent;

        if (flush_i) begin
            for (int i = 0; i < 4; i++) ent_d[i].valid = 1'b0;
        end
    end

    always_comb begin
        iss_valid_d    = iss_valid_q;
        iss_r0_d       = iss_r0_q;
        iss_r1_d       = iss_r1_q;
        iss_pc_d       = iss_pc_q;
        iss_grand_op_d = iss_grand_op_q;
        iss_op_d       = iss_op_q;
        iss_dst_tag_d  = iss_dst_tag_q;
        if (load) begin
            iss_valid_d    = 1'b1;
            iss_r0_d       = ent_q[sel_idx].src0_data;
            iss_r1_d       = ent_q[sel_idx].src1_data;
            iss_pc_d       = ent_q[sel_idx].pc;
            iss_grand_op_d = ent_q[sel_idx].grand_op;
            iss_op_d       = ent_q[sel_idx].op;
            iss_dst_tag_d  = ent_q[sel_idx].dst_tag;
        end else if (iss_ready_i) begin
            iss_valid_d = 1'b0;
        end
        if (flush_i) iss_valid_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) ent_q[i] <= '0;
            iss_valid_q    <= 1'b0;
            iss_r0_q       <= '0;
            iss_r1_q       <= '0;
            iss_pc_q       <= '0;
            iss_grand_op_q <= '0;
            iss_op_q       <= '0;
            iss_dst_tag_q  <= '0;
        end else begin
            for (int i = 0; i < 4; i++) ent_q[i] <= ent_d[i];
            iss_valid_q    <= iss_valid_d;
            iss_r0_q       <= iss_r0_d;
            iss_r1_q       <= iss_r1_d;
            iss_pc_q       <= iss_pc_d;
            iss_grand_op_q <= iss_grand_op_d;
            iss_op_q       <= iss_op_d;
            iss_dst_tag_q  <= iss_dst_tag_d;
        end
    end

    assign iss_valid_o    = iss_valid_q;
    assign iss_r0_o       = iss_r0_q;
    assign iss_r1_o       = iss_r1_q;
    assign iss_pc_o       = iss_pc_q;
    assign iss_grand_op_o = iss_grand_op_q;
    assign iss_op_o       = iss_op_q;
    assign iss_dst_tag_o  = iss_dst_tag_q;

endmodule

// File: tb/tb_e_alu_iq.sv
// Bench for e_alu_iq: directed scenarios plus random traffic against an age-ordered queue model.
// The model pushes each instruction it moves to the output register; a monitor pops on every handshake.
module tb_e_alu_iq;

    logic        clk;
    logic        rst;
    logic        flush_i;
    logic        dsp_valid_i;
    logic        dsp_ready_o;
    logic [2:0]  dsp_grand_op_i;
    logic [2:0]  dsp_op_i;
    logic [31:0] dsp_pc_i;
    logic        dsp_src0_rdy_i;
    logic [5:0]  dsp_src0_tag_i;
    logic [31:0] dsp_src0_data_i;
    logic        dsp_src1_rdy_i;
    logic [5:0]  dsp_src1_tag_i;
    logic [31:0] dsp_src1_data_i;
    logic [5:0]  dsp_dst_tag_i;
    logic        wk_valid_i;
    logic [5:0]  wk_tag_i;
    logic [31:0] wk_data_i;
    logic        iss_valid_o;
    logic        iss_ready_i;
    logic [31:0] iss_r0_o;
    logic [31:0] iss_r1_o;
    logic [31:0] iss_pc_o;
    logic [2:0]  iss_grand_op_o;
    logic [2:0]  iss_op_o;
    logic [5:0]  iss_dst_tag_o;

    e_alu_iq dut (
        .clk(clk), .rst(rst), .flush_i(flush_i),
        .dsp_valid_i(dsp_valid_i), .dsp_ready_o(dsp_ready_o),
        .dsp_grand_op_i(dsp_grand_op_i), .dsp_op_i(dsp_op_i), .dsp_pc_i(dsp_pc_i),
        .dsp_src0_rdy_i(dsp_src0_rdy_i), .dsp_src0_tag_i(dsp_src0_tag_i), .dsp_src0_data_i(dsp_src0_data_i),
        .dsp_src1_rdy_i(dsp_src1_rdy_i), .dsp_src1_tag_i(dsp_src1_tag_i), .dsp_src1_data_i(dsp_src1_data_i),
        .dsp_dst_tag_i(dsp_dst_tag_i),
        .wk_valid_i(wk_valid_i), .wk_tag_i(wk_tag_i), .wk_data_i(wk_data_i),
        .iss_valid_o(iss_valid_o), .iss_ready_i(iss_ready_i),
        .iss_r0_o(iss_r0_o), .iss_r1_o(iss_r1_o), .iss_pc_o(iss_pc_o),
        .iss_grand_op_o(iss_grand_op_o), .iss_op_o(iss_op_o), .iss_dst_tag_o(iss_dst_tag_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        bit [2:0]  gop;
        bit [2:0]  op;
        bit [31:0] pc;
        bit [5:0]  dst;
        bit        r0_rdy;
        bit [5:0]  r0_tag;
        bit [31:0] r0_data;
        bit        r1_rdy;
        bit [5:0]  r1_tag;
        bit [31:0] r1_data;
    } instr_t;

    instr_t mq[$];
    instr_t sb[$];
    bit     m_out_valid;
    int     checks   = 0;
    int     failures = 0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic instr_t mk(input bit [31:0] pc, input bit a_rdy, input bit [5:0] a_tag,
                                  input bit [31:0] a_data, input bit b_rdy, input bit [5:0] b_tag,
                                  input bit [31:0] b_data, input bit [5:0] dst);
        instr_t e;
        e.gop = pc[4:2]; e.op = pc[7:5]; e.pc = pc; e.dst = dst;
        e.r0_rdy = a_rdy; e.r0_tag = a_tag; e.r0_data = a_data;
        e.r1_rdy = b_rdy; e.r1_tag = b_tag; e.r1_data = b_data;
        return e;
    endfunction

    function automatic instr_t wakeInstr(input instr_t e);
        instr_t r = e;
        if (wk_valid_i && !r.r0_rdy && r.r0_tag == wk_tag_i) begin r.r0_rdy = 1; r.r0_data = wk_data_i; end
        if (wk_valid_i && !r.r1_rdy && r.r1_tag == wk_tag_i) begin r.r1_rdy = 1; r.r1_data = wk_data_i; end
        return r;
    endfunction

    // Behavioural queue: oldest-first list, ready instructions leave in age order.
    task automatic modelStep();
        instr_t picked, d;
        int     pick;
        bit     can_take, do_load;
        if (rst || flush_i) begin
            mq.delete();
            sb.delete();
            m_out_valid = 0;
            return;
        end
        can_take = mq.size() < 4;
        pick = -1;
        foreach (mq[i]) if (pick < 0 && mq[i].r0_rdy && mq[i].r1_rdy) pick = i;
        do_load = (pick >= 0) && (!m_out_valid || iss_ready_i);
        picked = '0;
        if (do_load) picked = mq[pick];
        foreach (mq[i]) mq[i] = wakeInstr(mq[i]);
        if (do_load) begin
            mq.delete(pick);
            sb.push_back(picked);
            m_out_valid = 1;
        end else if (iss_ready_i) begin
            m_out_valid = 0;
        end
        if (dsp_valid_i && can_take) begin
            d = mk(dsp_pc_i, dsp_src0_rdy_i, dsp_src0_tag_i, dsp_src0_data_i,
                   dsp_src1_rdy_i, dsp_src1_tag_i, dsp_src1_data_i, dsp_dst_tag_i);
            d.gop = dsp_grand_op_i;
            d.op  = dsp_op_i;
            mq.push_back(wakeInstr(d));
        end
    endtask

    task automatic applyStimulus(input bit dv, input instr_t e, input bit wv, input bit [5:0] wt,
                                 input bit [31:0] wd, input bit ir, input bit fl, input bit r);
        dsp_valid_i = dv;     dsp_grand_op_i = e.gop; dsp_op_i = e.op; dsp_pc_i = e.pc;
        dsp_src0_rdy_i = e.r0_rdy; dsp_src0_tag_i = e.r0_tag; dsp_src0_data_i = e.r0_data;
        dsp_src1_rdy_i = e.r1_rdy; dsp_src1_tag_i = e.r1_tag; dsp_src1_data_i = e.r1_data;
        dsp_dst_tag_i = e.dst;
        wk_valid_i = wv; wk_tag_i = wt; wk_data_i = wd;
        iss_ready_i = ir; flush_i = fl; rst = r;
    endtask

    task automatic tick();
        @(posedge clk);
        modelStep();
        #1;
    endtask

    task automatic idle(input bit ir);
        applyStimulus(0, '0, 0, 6'd0, 32'd0, ir, 0, 0);
    endtask

    // Monitor: state flags every cycle, scoreboard pop on each accepted issue.
    initial begin
        instr_t exp;
        forever begin
            @(negedge clk);
            checkOutput("mon_iss_valid", 32'(iss_valid_o), 32'(m_out_valid));
            checkOutput("mon_dsp_ready", 32'(dsp_ready_o), 32'(mq.size() < 4));
            if (iss_valid_o && iss_ready_i && !flush_i && !rst) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL mon_unexpected_issue: got pc 0x%08h expected no issue", iss_pc_o);
                end else begin
                    exp = sb.pop_front();
                    checkOutput("mon_pc", iss_pc_o, exp.pc);
                    checkOutput("mon_r0", iss_r0_o, exp.r0_data);
                    checkOutput("mon_r1", iss_r1_o, exp.r1_data);
                    checkOutput("mon_op_dst", 32'({iss_grand_op_o, iss_op_o, iss_dst_tag_o}),
                                32'({exp.gop, exp.op, exp.dst}));
                end
            end
        end
    end

    initial begin
        instr_t e, e1;
        applyStimulus(0, '0, 0, 6'd0, 32'd0, 0, 0, 1);
        tick();
        tick();
        idle(0);
        checkOutput("rst_dsp_ready", 32'(dsp_ready_o), 32'd1);
        checkOutput("rst_iss_valid", 32'(iss_valid_o), 32'd0);
        checkOutput("rst_r0", iss_r0_o, 32'd0);
        checkOutput("rst_r1", iss_r1_o, 32'd0);
        checkOutput("rst_pc", iss_pc_o, 32'd0);
        checkOutput("rst_op_dst", 32'({iss_grand_op_o, iss_op_o, iss_dst_tag_o}), 32'd0);

        // Ready ADD: visible two edges after dispatch.
        e = mk(32'h1C000000, 1, 6'd0, 32'd5, 1, 6'd0, 32'd7, 6'd1);
        applyStimulus(1, e, 0, 6'd0, 32'd0, 1, 0, 0); tick();
        checkOutput("add_not_yet", 32'(iss_valid_o), 32'd0);
        idle(1); tick();
        checkOutput("add_valid", 32'(iss_valid_o), 32'd1);
        checkOutput("add_r0", iss_r0_o, 32'd5);
        checkOutput("add_r1", iss_r1_o, 32'd7);
        checkOutput("add_pc", iss_pc_o, 32'h1C000000);
        idle(1); tick();
        checkOutput("add_drained", 32'(iss_valid_o), 32'd0);
        checkOutput("add_empty_ready", 32'(dsp_ready_o), 32'd1);

        // src1 waits on tag 0x12 until broadcast.
        e = mk(32'h100, 1, 6'd0, 32'd3, 0, 6'h12, 32'd0, 6'd2);
        applyStimulus(1, e, 0, 6'd0, 32'd0, 1, 0, 0); tick();
        idle(1); tick();
        checkOutput("wk_waiting", 32'(iss_valid_o), 32'd0);
        applyStimulus(0, '0, 1, 6'h12, 32'hDEADBEEF, 1, 0, 0); tick();
        checkOutput("wk_edge", 32'(iss_valid_o), 32'd0);
        idle(1); tick();
        checkOutput("wk_issue", 32'(iss_valid_o), 32'd1);
        checkOutput("wk_r1", iss_r1_o, 32'hDEADBEEF);
        idle(1); tick();

        // Same-cycle wakeup bypass on dispatch.
        e = mk(32'h200, 0, 6'h21, 32'd0, 1, 6'd0, 32'd9, 6'd3);
        applyStimulus(1, e, 1, 6'h21, 32'hCAFEF00D, 1, 0, 0); tick();
        idle(1); tick();
        checkOutput("byp_valid", 32'(iss_valid_o), 32'd1);
        checkOutput("byp_r0", iss_r0_o, 32'hCAFEF00D);
        checkOutput("byp_r1", iss_r1_o, 32'd9);
        idle(1); tick();

        // Fill the queue behind a stalled output, then drain oldest-first.
        for (int k = 0; k < 5; k++) begin
            e = mk(32'h300 + 32'(4 * k), 1, 6'd0, 32'(k), 1, 6'd0, 32'(k + 10), 6'(k));
            applyStimulus(1, e, 0, 6'd0, 32'd0, 0, 0, 0); tick();
        end
        checkOutput("full_not_ready", 32'(dsp_ready_o), 32'd0);
        checkOutput("full_head_pc", iss_pc_o, 32'h300);
        for (int k = 1; k < 5; k++) begin
            idle(1); tick();
            checkOutput("full_order_pc", iss_pc_o, 32'h300 + 32'(4 * k));
            checkOutput("full_order_valid", 32'(iss_valid_o), 32'd1);
            if (k == 1) checkOutput("full_ready_back", 32'(dsp_ready_o), 32'd1);
        end
        idle(1); tick();

        // Younger ready entry overtakes an older waiting one.
        e  = mk(32'h400, 0, 6'h05, 32'd0, 1, 6'd0, 32'd1, 6'd4);
        e1 = mk(32'h404, 1, 6'd0, 32'd2, 1, 6'd0, 32'd3, 6'd5);
        applyStimulus(1, e, 0, 6'd0, 32'd0, 1, 0, 0); tick();
        applyStimulus(1, e1, 0, 6'd0, 32'd0, 1, 0, 0); tick();
        idle(1); tick();
        checkOutput("ooo_first_pc", iss_pc_o, 32'h404);
        applyStimulus(0, '0, 1, 6'h05, 32'h55, 1, 0, 0); tick();
        idle(1); tick();
        checkOutput("ooo_second_pc", iss_pc_o, 32'h400);
        checkOutput("ooo_second_r0", iss_r0_o, 32'h55);
        idle(1); tick();

        // Stall holds outputs; flush then wipes everything.
        e  = mk(32'h500, 1, 6'd0, 32'hA5, 1, 6'd0, 32'h5A, 6'd6);
        e1 = mk(32'h504, 1, 6'd0, 32'd1, 1, 6'd0, 32'd2, 6'd7);
        applyStimulus(1, e, 0, 6'd0, 32'd0, 0, 0, 0); tick();
        applyStimulus(1, e1, 0, 6'd0, 32'd0, 0, 0, 0); tick();
        for (int k = 0; k < 3; k++) begin
            idle(0); tick();
            checkOutput("stall_pc", iss_pc_o, 32'h500);
            checkOutput("stall_r0", iss_r0_o, 32'hA5);
            checkOutput("stall_valid", 32'(iss_valid_o), 32'd1);
        end
        applyStimulus(1, e1, 1, 6'd1, 32'd1, 0, 1, 0); tick();
        checkOutput("flush_valid", 32'(iss_valid_o), 32'd0);
        checkOutput("flush_ready", 32'(dsp_ready_o), 32'd1);
        idle(1); tick();
        checkOutput("flush_empty", 32'(iss_valid_o), 32'd0);

        // Random traffic with occasional flush and mid-run reset.
        for (int n = 0; n < 1500; n++) begin
            e = mk($urandom, $urandom_range(9, 0) < 6, 6'($urandom_range(7, 0)), $urandom,
                   $urandom_range(9, 0) < 6, 6'($urandom_range(7, 0)), $urandom,
                   6'($urandom_range(63, 0)));
            e.gop = 3'($urandom_range(7, 0));
            e.op  = 3'($urandom_range(7, 0));
            applyStimulus(1'($urandom_range(1, 0)), e, 1'($urandom_range(1, 0)),
                          6'($urandom_range(7, 0)), $urandom, $urandom_range(3, 0) != 0,
                          $urandom_range(49, 0) == 0, $urandom_range(99, 0) == 0);
            tick();
        end

        for (int n = 0; n < 30; n++) begin
            applyStimulus(0, '0, n < 16, 6'(n % 8), $urandom, 1, 0, 0);
            tick();
        end
        checkOutput("drain_sb_empty", 32'(sb.size()), 32'd0);
        checkOutput("drain_ready", 32'(dsp_ready_o), 32'd1);
        checkOutput("drain_valid", 32'(iss_valid_o), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/e_alu_iq.md
E_ALU_IQ -- requirements
Module: e_alu_iq

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, named as below.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 flush_i  input  1  pipeline flush; discards all queued and issued-but-unaccepted work.
REQ-005 dsp_valid_i / dsp_ready_o  input/output  1/1  dispatch handshake; transfer when both are high.
REQ-006 dsp_grand_op_i, dsp_op_i  input  3, 3  ALU operation class and sub-op, carried through unchanged.
REQ-007 dsp_pc_i  input  32  instruction PC.
REQ-008 dsp_src0_rdy_i, dsp_src0_tag_i, dsp_src0_data_i  input  1, 6, 32  operand 0 state.
REQ-009 dsp_src1_rdy_i, dsp_src1_tag_i, dsp_src1_data_i  input  1, 6, 32  operand 1 state.
REQ-010 dsp_dst_tag_i  input  6  destination physical tag.
REQ-011 wk_valid_i, wk_tag_i, wk_data_i  input  1, 6, 32  single result-broadcast (wakeup) port.
REQ-012 iss_valid_o / iss_ready_i  output/input  1/1  issue handshake to the ALU stage.
REQ-013 iss_r0_o, iss_r1_o, iss_pc_o  output  32 each  operands and PC, driving the ALU r0/r1/pc inputs.
REQ-014 iss_grand_op_o, iss_op_o, iss_dst_tag_o  output  3, 3, 6  operation and destination tag.

Function
REQ-015 The queue SHALL hold 4 entries, kept collapsed and age-ordered: slot 0 holds the oldest entry.
REQ-016 Each entry SHALL store valid, grand_op, op, pc, dst_tag, and per operand rdy, tag and data.
REQ-017 dsp_ready_o SHALL be 1 iff the registered occupancy is below 4; a same-cycle issue does not raise it.
REQ-018 An accepted dispatch SHALL write into the first free slot after the collapse for any entry leaving that cycle.
REQ-019 Wakeup: for each valid entry and for the dispatching instruction, an operand with rdy=0 and tag==wk_tag_i while wk_valid_i=1 SHALL set rdy=1 and capture wk_data_i.
REQ-020 This wakeup bypass SHALL also apply in the dispatch cycle, so the entry is stored already ready.
REQ-021 Select: an entry is eligible when both operands were ready at the start of the cycle; the lowest-index eligible entry SHALL be chosen.
REQ-022 The block SHALL have one output register. It loads when it is empty, or when iss_ready_i=1 in the same cycle, and an eligible entry exists.
REQ-023 Loading the output register SHALL remove the chosen entry and shift all younger entries down by one slot in the same edge.
REQ-024 Latency: an entry dispatched ready in cycle N SHALL present iss_valid_o=1 in cycle N+2 at the earliest. Entry write occurs at edge N→N+1; select/load at edge N+1→N+2.
REQ-025 iss_valid_o and all iss_* fields SHALL stay stable while iss_valid_o=1 and iss_ready_i=0.
REQ-026 Back-to-back issue SHALL be supported: one issue per cycle while iss_ready_i=1 and eligible entries exist.
REQ-027 Simultaneous dispatch, wakeup and issue in one cycle SHALL all take effect; occupancy changes by (+dispatch − issue).
REQ-028 flush_i=1 SHALL clear all entry valids and iss_valid_o at the next edge and ignore dispatch and wakeup in that cycle; flush takes priority over everything except rst.
REQ-029 A wakeup for a tag with no matching waiting operand SHALL have no effect; matches on already-ready operands SHALL be ignored.

Reset
REQ-030 With rst=1 at an edge, all entry valids and iss_valid_o SHALL become 0, and occupancy SHALL become 0.
REQ-031 After reset, dsp_ready_o SHALL be 1, and iss_* data outputs SHALL be 0.
REQ-032 A reset arriving mid-operation SHALL discard all state without issuing.

Verification
REQ-033 Ready dispatch of ADD, pc=0x1C000000, r0=5, r1=7, with iss_ready_i=1: iss_valid_o=1 two cycles later with r0=5, r1=7; the queue is then empty.
REQ-034 Dispatch src1 waiting on tag 0x12, then wk_valid_i with tag 0x12 and data 0xDEADBEEF: issue occurs one cycle after the wakeup edge with iss_r1_o=0xDEADBEEF.
REQ-035 Fill 4 entries with iss_ready_i=0: dsp_ready_o=0. Raise iss_ready_i: issue order is oldest-first and dsp_ready_o returns to 1.
REQ-036 Entry 0 waiting and entry 1 ready: entry 1 issues first, and entry 0 issues after its wakeup, in slot 0.
REQ-037 Hold iss_ready_i=0 with iss_valid_o=1 for 3 cycles: outputs remain unchanged. Then assert flush_i: the next cycle has iss_valid_o=0, the queue is empty, and dsp_ready_o=1.
REQ-038 Wakeup tag equal to the dispatching src0 tag in the same cycle: the entry is stored ready and issues two cycles later with the wakeup data.
